writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter.sv | 167 ++++++++++++++++
 tb/tb_writeback_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges the single-cycle pipeline writeback with results from
// a multi-cycle unit (MDU). MDU results are buffered in a small FIFO. The pipeline
// always has priority. A per-register scoreboard tracks outstanding MDU writes, and
// a starvation counter asks the pipeline to pause so the FIFO can drain.
module writeback_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_we,
  input  logic [4:0]               wb_rd,
  input  logic [31:0]              wb_data,
  input  logic                     mdu_valid,
  output logic                     mdu_ready,
  input  logic [4:0]               mdu_rd,
  input  logic [31:0]              mdu_data,
  input  logic                     issue_valid,
  input  logic [4:0]               issue_rd,
  input  logic [4:0]               rs_addr,
  input  logic [4:0]               rt_addr,
  output logic                     rs_pending,
  output logic                     rt_pending,
  output logic                     wb_stall,
  output logic                     RegWrite,
  output logic [4:0]               Write_register,
  output logic [31:0]              Write_data,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  // FIFO storage and control state
  logic [4:0]    mem_rd   [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Scoreboard: bit 0 is never set since r0 is never written
  logic [31:0]   pending_q, pending_d;

  logic [SW-1:0] starve_q, starve_d;

  // Registered register-file write port
  logic          reg_write_q, reg_write_d;
  logic [4:0]    write_reg_q, write_reg_d;
  logic [31:0]   write_data_q, write_data_d;

  logic          push_en;
  logic          pop_en;
  logic          pipe_sel;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;

  // Handshake, arbitration decision and scoreboard queries
  always_comb begin
    mdu_ready  = (count_q < CNT_FULL);
    // r0 results are accepted but dropped, so they never occupy an entry
    push_en    = mdu_valid && mdu_ready && (mdu_rd != 5'd0);
    pipe_sel   = wb_we && (wb_rd != 5'd0);
    pop_en     = !pipe_sel && (count_q != '0);
    head_rd    = mem_rd[rd_ptr_q];
    head_data  = mem_data[rd_ptr_q];
    rs_pending = (rs_addr != 5'd0) && pending_q[rs_addr];
    rt_pending = (rt_addr != 5'd0) && pending_q[rt_addr];
    wb_stall   = (starve_q == STARVE_MAX);
    fifo_count = count_q;
  end

  // Next-state for pointers, occupancy, scoreboard, starvation and write port
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    pending_d    = pending_q;
    starve_d     = starve_q;
    reg_write_d  = 1'b0;
    write_reg_d  = 5'd0;
    write_data_d = 32'd0;

    if (push_en) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Clear first so a same-cycle issue to the same register wins
    if (pop_en) begin
      pending_d[head_rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      pending_d[issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;

    if ((count_q == '0) || pop_en) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + STARVE_ONE;
    end

    if (pipe_sel) begin
      reg_write_d  = 1'b1;
      write_reg_d  = wb_rd;
      write_data_d = wb_data;
    end else if (pop_en) begin
      reg_write_d  = 1'b1;
      write_reg_d  = head_rd;
      write_data_d = head_data;
    end
  end

  // Control state register with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pending_q    <= '0;
      starve_q     <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= 5'd0;
      write_data_q <= 32'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pending_q    <= pending_d;
      starve_q     <= starve_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  // FIFO payload storage; contents are only meaningful while counted, so no reset
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_rd[wr_ptr_q]   <= mdu_rd;
      mem_data[wr_ptr_q] <= mdu_data;
    end
  end

  // Drive the register-file write port from its registers
  always_comb begin
    RegWrite       = reg_write_q;
    Write_register = write_reg_q;
    Write_data     = write_data_q;
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with a scoreboard of expected writes.
module tb_writeback_arbiter;

  logic        clk;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        rs_pending;
  logic        rt_pending;
  logic        wb_stall;
  logic        RegWrite;
  logic [4:0]  Write_register;
  logic [31:0] Write_data;
  logic [2:0]  fifo_count;

  int checks;
  int failures;

  // Expected writes: pipeline ones pushed when driven, MDU ones pushed when accepted
  logic [36:0] pipe_q[$];
  logic [36:0] mdu_q[$];

  writeback_arbiter #(
    .DEPTH(4),
    .STARVE_LIMIT(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wb_we(wb_we),
    .wb_rd(wb_rd),
    .wb_data(wb_data),
    .mdu_valid(mdu_valid),
    .mdu_ready(mdu_ready),
    .mdu_rd(mdu_rd),
    .mdu_data(mdu_data),
    .issue_valid(issue_valid),
    .issue_rd(issue_rd),
    .rs_addr(rs_addr),
    .rt_addr(rt_addr),
    .rs_pending(rs_pending),
    .rt_pending(rt_pending),
    .wb_stall(wb_stall),
    .RegWrite(RegWrite),
    .Write_register(Write_register),
    .Write_data(Write_data),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_mdu(input logic [4:0] rd, input logic [31:0] data);
    mdu_q.push_back({rd, data});
  endtask

  // Record pipeline writes the DUT must reproduce one cycle later
  always @(posedge clk) begin
    if (!reset && wb_we && (wb_rd != 5'd0)) pipe_q.push_back({wb_rd, wb_data});
  end

  always @(posedge reset) begin
    pipe_q.delete();
    mdu_q.delete();
  end

  // Pop and compare each write the DUT produces
  always @(negedge clk) begin
    logic [36:0] e;
    if (!reset) begin
      if (pipe_q.size() != 0) begin
        e = pipe_q.pop_front();
        check("pipe_we", {31'd0, RegWrite}, 32'd1);
        check("pipe_rd", {27'd0, Write_register}, {27'd0, e[36:32]});
        check("pipe_data", Write_data, e[31:0]);
      end else if (RegWrite) begin
        if (mdu_q.size() == 0) begin
          check("unexpected_write", {31'd0, RegWrite}, 32'd0);
        end else begin
          e = mdu_q.pop_front();
          check("mdu_rd", {27'd0, Write_register}, {27'd0, e[36:32]});
          check("mdu_data", Write_data, e[31:0]);
        end
      end
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
    rs_addr = '0; rt_addr = '0;
    #1;
    check("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_stall", {31'd0, wb_stall}, 32'd0);
    step(); step();
    reset = 1'b0;
    check("rst_ready", {31'd0, mdu_ready}, 32'd1);

    // Pipeline only
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
    step();
    check("pipe_regwrite", {31'd0, RegWrite}, 32'd1);
    check("pipe_reg5", {27'd0, Write_register}, 32'd5);
    check("pipe_data1234", Write_data, 32'h1234);
    wb_rd = 5'd0; wb_data = 32'hFFFF;
    step();
    check("r0_regwrite", {31'd0, RegWrite}, 32'd0);
    check("r0_reg", {27'd0, Write_register}, 32'd0);
    check("r0_data", Write_data, 32'd0);
    wb_we = 1'b0;

    // MDU idle path with scoreboard
    issue_valid = 1'b1; issue_rd = 5'd8; rs_addr = 5'd8;
    step();
    issue_valid = 1'b0;
    check("pend8_set", {31'd0, rs_pending}, 32'd1);
    mdu_valid = 1'b1; mdu_rd = 5'd8; mdu_data = 32'hDEADBEEF;
    expect_mdu(5'd8, 32'hDEADBEEF);
    step();
    mdu_valid = 1'b0;
    check("mdu_count1", {29'd0, fifo_count}, 32'd1);
    check("pend8_hold", {31'd0, rs_pending}, 32'd1);
    check("mdu_lat_n1", {31'd0, RegWrite}, 32'd0);
    step();
    check("mdu_lat_n2", {31'd0, RegWrite}, 32'd1);
    check("mdu_reg8", {27'd0, Write_register}, 32'd8);
    check("mdu_deadbeef", Write_data, 32'hDEADBEEF);
    check("pend8_clr", {31'd0, rs_pending}, 32'd0);
    check("mdu_count0", {29'd0, fifo_count}, 32'd0);

    // Contention: pipeline every cycle while four results queue up
    wb_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wb_rd = 5'(10 + i); wb_data = 32'h100 + 32'(i);
      mdu_valid = 1'b1; mdu_rd = 5'(i + 1); mdu_data = 32'hA000 + 32'(i);
      expect_mdu(5'(i + 1), 32'hA000 + 32'(i));
      step();
    end
    mdu_valid = 1'b0;
    wb_rd = 5'd15; wb_data = 32'h15;
    check("full_count", {29'd0, fifo_count}, 32'd4);
    check("full_ready", {31'd0, mdu_ready}, 32'd0);
    repeat (4) step();
    check("stall_7", {31'd0, wb_stall}, 32'd0);
    step();
    check("stall_8", {31'd0, wb_stall}, 32'd1);
    step();
    check("stall_hold", {31'd0, wb_stall}, 32'd1);
    check("stall_count", {29'd0, fifo_count}, 32'd4);
    // Pop while full: this offer must be refused
    wb_we = 1'b0;
    mdu_valid = 1'b1; mdu_rd = 5'd20; mdu_data = 32'hBAD;
    check("full_pop_ready", {31'd0, mdu_ready}, 32'd0);
    step();
    mdu_valid = 1'b0;
    check("full_pop_count", {29'd0, fifo_count}, 32'd3);
    check("stall_clr", {31'd0, wb_stall}, 32'd0);
    repeat (3) step();
    check("drain_count", {29'd0, fifo_count}, 32'd0);
    step();
    check("drain_idle", {31'd0, RegWrite}, 32'd0);
    check("drain_sb", 32'(mdu_q.size()), 32'd0);

    // Simultaneous push and pop at count 2
    wb_we = 1'b1; wb_rd = 5'd30; wb_data = 32'h30;
    for (int i = 0; i < 2; i++) begin
      mdu_valid = 1'b1; mdu_rd = 5'(11 + i); mdu_data = 32'hB000 + 32'(i);
      expect_mdu(5'(11 + i), 32'hB000 + 32'(i));
      step();
    end
    check("pp_count2", {29'd0, fifo_count}, 32'd2);
    wb_we = 1'b0;
    mdu_rd = 5'd13; mdu_data = 32'hB002;
    expect_mdu(5'd13, 32'hB002);
    step();
    mdu_valid = 1'b0;
    check("pp_same", {29'd0, fifo_count}, 32'd2);
    step(); step();
    check("pp_drain", {29'd0, fifo_count}, 32'd0);
    step();
    check("pp_sb", 32'(mdu_q.size()), 32'd0);

    // Issue to rd 9 in the same cycle as its pop: pending must survive
    issue_valid = 1'b1; issue_rd = 5'd9; rs_addr = 5'd9; rt_addr = 5'd9;
    step();
    issue_valid = 1'b0;
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h99;
    expect_mdu(5'd9, 32'h99);
    step();
    mdu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    issue_valid = 1'b0;
    check("setwins_rs", {31'd0, rs_pending}, 32'd1);
    check("setwins_rt", {31'd0, rt_pending}, 32'd1);
    check("setwins_reg", {27'd0, Write_register}, 32'd9);
    rs_addr = 5'd0;
    #1;
    check("rs_zero", {31'd0, rs_pending}, 32'd0);
    // r0 result: accepted, dropped
    mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_data = 32'h55;
    check("r0_ready", {31'd0, mdu_ready}, 32'd1);
    step();
    mdu_valid = 1'b0;
    check("r0_count", {29'd0, fifo_count}, 32'd0);
    step();
    check("r0_nowrite", {31'd0, RegWrite}, 32'd0);

    // Reset mid-operation with three queued entries
    wb_we = 1'b1; wb_rd = 5'd30; wb_data = 32'h31;
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(i + 1);
      mdu_valid = 1'b1; mdu_rd = 5'(i + 1); mdu_data = 32'hC000 + 32'(i);
      expect_mdu(5'(i + 1), 32'hC000 + 32'(i));
      step();
    end
    issue_valid = 1'b0; mdu_valid = 1'b0;
    rs_addr = 5'd2;
    #1;
    check("prerst_count", {29'd0, fifo_count}, 32'd3);
    check("prerst_pend", {31'd0, rs_pending}, 32'd1);
    wb_we = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check("async_count", {29'd0, fifo_count}, 32'd0);
    check("async_regwrite", {31'd0, RegWrite}, 32'd0);
    check("async_pend", {31'd0, rs_pending}, 32'd0);
    check("async_ready", {31'd0, mdu_ready}, 32'd1);
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_idle", {31'd0, RegWrite}, 32'd0);
    end
    check("post_rst_count", {29'd0, fifo_count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
